// File: rtl/vga_pkg.sv
// Shared VGA/frame-buffer constants, scan FSM encoding and address packing.
// Pixel coordinates pack as {y, x} to match the line drawer's write port.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W_DEF    = 12;
    localparam int CNT_W        = 12;
    localparam int COORD_W      = 10;
    localparam int ADDR_W       = 2 * COORD_W;

    typedef enum logic {
        SCAN_OFF = 1'b0,
        SCAN_ON  = 1'b1
    } scan_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] y,
        input int               sh
    );
        logic [CNT_W-1:0] xs;
        logic [CNT_W-1:0] ys;
        xs = x >> sh;
        ys = y >> sh;
        return {ys[COORD_W-1:0], xs[COORD_W-1:0]};
    endfunction

endpackage

// File: rtl/fb_scan_reader_if.sv
// Read port between the scan-out reader and the frame-buffer RAM.
// The reader drives strobe and address; the RAM returns data.
interface fb_scan_reader_if #(
    parameter int PIX_W = 12
);
    import vga_pkg::*;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/fb_scan_reader_delay_line.sv
// Fixed-depth shift register used to align timing and flags with pixel data.
// Every stage clears on reset.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer scan-out reader: timing counters to RAM reads, with sync and
// blank delayed so pixels and syncs leave the block aligned.
module fb_scan_reader
    import vga_pkg::*;
#(
    parameter int              H_ACTIVE    = H_ACTIVE_DEF,
    parameter int              V_ACTIVE    = V_ACTIVE_DEF,
    parameter int              RD_LAT      = 2,
    parameter int              PIX_W       = PIX_W_DEF,
    parameter int              SCALE_SHIFT = 0,
    parameter logic [PIX_W-1:0] BG_COLOR   = '0
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [11:0]      hcnt,
    input  logic [11:0]      vcnt,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             blank_in,
    fb_scan_reader_if.master ram,
    output logic [PIX_W-1:0] pix_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             blank_out,
    output logic             scanning,
    output logic             vblank_start,
    output logic [7:0]       frame_cnt
);

    localparam int         L     = RD_LAT + 2;
    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

    scan_state_e       r_state;
    scan_state_e       w_state_nxt;
    logic              w_fs;
    logic              w_in_fb;
    logic              w_rd;
    logic              w_vbs;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_sync_q;
    logic [1:0]        w_rdf_q;
    logic [PIX_W-1:0]  w_pix_nxt;

    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_vbs;
    logic [7:0]        r_fcnt;
    logic [PIX_W-1:0]  r_pix;

    assign w_fs    = (hcnt == 12'd0) && (vcnt == 12'd0);
    assign w_in_fb = (hcnt < H_LIM) && (vcnt < V_LIM);
    assign w_vbs   = (hcnt == 12'd0) && (vcnt == V_LIM);
    assign w_addr  = pack_addr(hcnt, vcnt, SCALE_SHIFT);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SCAN_OFF: if (w_fs && enable)  w_state_nxt = SCAN_ON;
            SCAN_ON:  if (w_fs && !enable) w_state_nxt = SCAN_OFF;
            default:  w_state_nxt = SCAN_OFF;
        endcase
    end

    // Decide on the next state so the first pixel of an enabled frame is read.
    assign w_rd = w_in_fb && (w_state_nxt == SCAN_ON);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_vbs     <= 1'b0;
            r_fcnt    <= 8'd0;
            r_pix     <= '0;
        end else begin
            r_rd_en <= w_rd;
            if (w_rd) begin
                r_rd_addr <= w_addr;
            end
            r_vbs <= w_vbs;
            if (w_vbs && (r_state == SCAN_ON)) begin
                r_fcnt <= r_fcnt + 8'd1;
            end
            r_pix <= w_pix_nxt;
        end
    end

    delay_line #(
        .WIDTH (3),
        .DEPTH (L)
    ) u_sync_dly (
        .pclk  (pclk),
        .rst_n (rst_n),
        .i_d   ({hsync_in, vsync_in, blank_in}),
        .o_q   (w_sync_q)
    );

    // Blank rides with the read flag so the mux sees it one stage ahead.
    delay_line #(
        .WIDTH (2),
        .DEPTH (L - 1)
    ) u_rd_dly (
        .pclk  (pclk),
        .rst_n (rst_n),
        .i_d   ({blank_in, w_rd}),
        .o_q   (w_rdf_q)
    );

    always_comb begin
        w_pix_nxt = BG_COLOR;
        if (w_rdf_q[1]) begin
            w_pix_nxt = '0;
        end else if (w_rdf_q[0]) begin
            w_pix_nxt = ram.rd_data;
        end
    end

    assign ram.rd_en   = r_rd_en;
    assign ram.rd_addr = r_rd_addr;
    assign pix_out      = r_pix;
    assign hsync_out    = w_sync_q[2];
    assign vsync_out    = w_sync_q[1];
    assign blank_out    = w_sync_q[0];
    assign scanning     = (r_state == SCAN_ON);
    assign vblank_start = r_vbs;
    assign frame_cnt    = r_fcnt;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: two configurations checked against a
// history-based reference model plus directed vectors and sequences.
module tb_fb_scan_reader;

    localparam logic [11:0] BG = 12'h5A5;
    localparam int L0 = 4;
    localparam int L1 = 3;
    localparam int HN = 8192;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] hcnt = '0;
    logic [11:0] vcnt = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        blank_in = 1'b0;

    logic [11:0] o0_pix, o1_pix;
    logic        o0_hs, o0_vs, o0_bl, o0_scan, o0_vb;
    logic        o1_hs, o1_vs, o1_bl, o1_scan, o1_vb;
    logic [7:0]  o0_fc, o1_fc;

    fb_scan_reader_if #(.PIX_W(12)) if0 ();
    fb_scan_reader_if #(.PIX_W(12)) if1 ();

    fb_scan_reader #(
        .RD_LAT(2), .SCALE_SHIFT(0), .PIX_W(12), .BG_COLOR(BG)
    ) dut0 (
        .pclk(pclk), .rst_n(rst_n), .enable(enable),
        .hcnt(hcnt), .vcnt(vcnt),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .ram(if0),
        .pix_out(o0_pix), .hsync_out(o0_hs), .vsync_out(o0_vs),
        .blank_out(o0_bl), .scanning(o0_scan),
        .vblank_start(o0_vb), .frame_cnt(o0_fc)
    );

    fb_scan_reader #(
        .RD_LAT(1), .SCALE_SHIFT(1), .PIX_W(12), .BG_COLOR(BG)
    ) dut1 (
        .pclk(pclk), .rst_n(rst_n), .enable(enable),
        .hcnt(hcnt), .vcnt(vcnt),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .ram(if1),
        .pix_out(o1_pix), .hsync_out(o1_hs), .vsync_out(o1_vs),
        .blank_out(o1_bl), .scanning(o1_scan),
        .vblank_start(o1_vb), .frame_cnt(o1_fc)
    );

    always #5 pclk = ~pclk;

    function automatic logic [11:0] ramf(input logic [19:0] a);
        if (a == 20'h00C05) return 12'hABC;
        return a[11:0] ^ {2'b00, a[19:10]};
    endfunction

    logic [11:0] p0 [4];
    logic [11:0] p1 [4];

    always @(posedge pclk) begin
        p0[0] <= ramf(if0.rd_addr);
        p1[0] <= ramf(if1.rd_addr);
        for (int i = 1; i < 4; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
    end

    assign if0.rd_data = p0[1];
    assign if1.rd_data = p1[0];

    int n_chk = 0;
    int n_err = 0;
    int k = 0;
    int mark = 0;

    bit          m_scan = 1'b0;
    logic [19:0] m_a0 = '0;
    logic [19:0] m_a1 = '0;
    logic [7:0]  m_fc = '0;

    bit          h_rd [HN];
    bit          h_bl [HN];
    bit          h_hs [HN];
    bit          h_vs [HN];
    logic [19:0] h_a0 [HN];
    logic [19:0] h_a1 [HN];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d got %h want %h", nm, k, act, exp);
        end
    endtask

    task automatic exp_out(input int j, input int d, output logic [11:0] pix,
                           output bit hs, output bit vs, output bit bl);
        pix = BG;
        hs = 1'b0;
        vs = 1'b0;
        bl = 1'b0;
        if (j >= mark) begin
            hs = h_hs[j];
            vs = h_vs[j];
            bl = h_bl[j];
            if (h_bl[j]) pix = 12'h000;
            else if (h_rd[j]) pix = ramf(d == 0 ? h_a0[j] : h_a1[j]);
        end
    endtask

    task automatic step(input int h, input int v, input bit hs, input bit vs,
                        input bit bl, input bit en);
        bit fs, infb, rd, vbc;
        logic [11:0] ep;
        bit ehs, evs, ebl;
        hcnt = 12'(h);
        vcnt = 12'(v);
        hsync_in = hs;
        vsync_in = vs;
        blank_in = bl;
        enable = en;
        @(posedge pclk);
        #1;
        fs = (h == 0) && (v == 0);
        if (fs) m_scan = en;
        infb = (h < 640) && (v < 480);
        rd = infb && m_scan;
        if (rd) begin
            m_a0 = {10'(v), 10'(h)};
            m_a1 = {10'(v >> 1), 10'(h >> 1)};
        end
        vbc = (h == 0) && (v == 480);
        if (vbc && m_scan) m_fc = m_fc + 8'd1;
        h_rd[k] = rd;
        h_bl[k] = bl;
        h_hs[k] = hs;
        h_vs[k] = vs;
        h_a0[k] = m_a0;
        h_a1[k] = m_a1;
        chk("m_rd_en0", 32'(if0.rd_en), 32'(rd));
        chk("m_rd_en1", 32'(if1.rd_en), 32'(rd));
        chk("m_addr0", 32'(if0.rd_addr), 32'(m_a0));
        chk("m_addr1", 32'(if1.rd_addr), 32'(m_a1));
        chk("m_scan0", 32'(o0_scan), 32'(m_scan));
        chk("m_scan1", 32'(o1_scan), 32'(m_scan));
        chk("m_vb0", 32'(o0_vb), 32'(vbc));
        chk("m_fc0", 32'(o0_fc), 32'(m_fc));
        chk("m_fc1", 32'(o1_fc), 32'(m_fc));
        exp_out(k - L0 + 1, 0, ep, ehs, evs, ebl);
        chk("m_pix0", 32'(o0_pix), 32'(ep));
        chk("m_hs0", 32'(o0_hs), 32'(ehs));
        chk("m_vs0", 32'(o0_vs), 32'(evs));
        chk("m_bl0", 32'(o0_bl), 32'(ebl));
        exp_out(k - L1 + 1, 1, ep, ehs, evs, ebl);
        chk("m_pix1", 32'(o1_pix), 32'(ep));
        chk("m_hs1", 32'(o1_hs), 32'(ehs));
        chk("m_bl1", 32'(o1_bl), 32'(ebl));
        k++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(if0.rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(if0.rd_addr), 32'd0);
        chk({tag, "_pix"}, 32'(o0_pix), 32'd0);
        chk({tag, "_hs"}, 32'(o0_hs), 32'd0);
        chk({tag, "_vs"}, 32'(o0_vs), 32'd0);
        chk({tag, "_bl"}, 32'(o0_bl), 32'd0);
        chk({tag, "_scan"}, 32'(o0_scan), 32'd0);
        chk({tag, "_vb"}, 32'(o0_vb), 32'd0);
        chk({tag, "_fc"}, 32'(o0_fc), 32'd0);
        chk({tag, "_fc1"}, 32'(o1_fc), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        m_scan = 1'b0;
        m_a0 = '0;
        m_a1 = '0;
        m_fc = '0;
        mark = k;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          h;
        int          v;
        bit          bl;
        bit          en_exp;
        logic [19:0] a0;
        logic [19:0] a1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1000000;
        $display("FAIL watchdog step %0d", k);
        $fatal(1);
    end

    initial begin
        bit ren;
        tbl[0] = '{5,    3,    1'b0, 1'b1, 20'h00C05, 20'h00402};
        tbl[1] = '{7,    9,    1'b0, 1'b1, 20'h02407, 20'h01003};
        tbl[2] = '{700,  9,    1'b0, 1'b0, 20'h02407, 20'h01003};
        tbl[3] = '{639,  479,  1'b0, 1'b1, 20'h77E7F, 20'h3BD3F};
        tbl[4] = '{640,  0,    1'b0, 1'b0, 20'h77E7F, 20'h3BD3F};
        tbl[5] = '{0,    480,  1'b1, 1'b0, 20'h77E7F, 20'h3BD3F};
        tbl[6] = '{4095, 4095, 1'b1, 1'b0, 20'h77E7F, 20'h3BD3F};
        tbl[7] = '{100,  200,  1'b0, 1'b1, 20'h32064, 20'h19032};

        // Power-on reset, release with enable high mid-frame.
        #1;
        do_reset("rst");
        step(100, 0, 0, 0, 0, 1);
        chk("rel_no_rd", 32'(if0.rd_en), 32'd0);
        step(101, 0, 0, 0, 0, 1);
        step(102, 5, 0, 0, 0, 1);
        chk("rel_no_scan", 32'(o0_scan), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("fs_rd_en", 32'(if0.rd_en), 32'd1);
        chk("fs_addr", 32'(if0.rd_addr), 32'd0);
        chk("fs_scan", 32'(o0_scan), 32'd1);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].h, tbl[i].v, 0, 0, tbl[i].bl, 1);
            chk("tbl_rd_en", 32'(if0.rd_en), 32'(tbl[i].en_exp));
            chk("tbl_addr0", 32'(if0.rd_addr), 32'(tbl[i].a0));
            chk("tbl_addr1", 32'(if1.rd_addr), 32'(tbl[i].a1));
        end

        // Latency and alignment of one pixel.
        step(5, 3, 1, 0, 0, 1);
        chk("al_addr", 32'(if0.rd_addr), 32'h00C05);
        step(700, 3, 0, 0, 1, 1);
        step(700, 3, 0, 0, 1, 1);
        step(700, 3, 0, 0, 1, 1);
        chk("al_pix", 32'(o0_pix), 32'hABC);
        chk("al_hs", 32'(o0_hs), 32'd1);
        chk("al_bl", 32'(o0_bl), 32'd0);

        // Outside the visible window.
        step(700, 5, 0, 0, 0, 1);
        chk("out_rd_en", 32'(if0.rd_en), 32'd0);
        for (int i = 0; i < 3; i++) step(700, 5, 0, 0, 0, 1);
        chk("out_bg", 32'(o0_pix), 32'(BG));
        for (int i = 0; i < 4; i++) step(700, 5, 0, 0, 1, 1);
        chk("out_blank", 32'(o0_pix), 32'd0);

        // Drop enable mid-frame.
        step(10, 10, 0, 0, 0, 0);
        chk("drop_rd", 32'(if0.rd_en), 32'd1);
        step(11, 10, 0, 0, 0, 0);
        chk("drop_addr", 32'(if0.rd_addr), 32'h0280B);
        step(0, 480, 0, 0, 1, 0);
        chk("vb_pulse", 32'(o0_vb), 32'd1);
        step(1, 480, 0, 0, 1, 0);
        chk("vb_once", 32'(o0_vb), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("drop_off", 32'(o0_scan), 32'd0);
        chk("drop_no_rd", 32'(if0.rd_en), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("reen_scan", 32'(o0_scan), 32'd1);

        // Frame counter wrap.
        for (int i = 0; i < 300 && m_fc != 8'hFF; i++) begin
            step(0, 480, 0, 1, 1, 1);
            step(1, 480, 0, 1, 1, 1);
        end
        chk("fc_ff", 32'(o0_fc), 32'h0FF);
        step(0, 480, 0, 1, 1, 1);
        chk("fc_wrap", 32'(o0_fc), 32'h000);

        // Asynchronous reset mid-scan.
        step(0, 0, 0, 0, 0, 1);
        step(20, 20, 1, 1, 0, 1);
        do_reset("arst");
        step(30, 20, 0, 0, 0, 1);
        chk("arst_off", 32'(o0_scan), 32'd0);
        chk("arst_no_rd", 32'(if0.rd_en), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("arst_resume", 32'(o0_scan), 32'd1);

        // Randomized counters, syncs and enable.
        ren = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r, h, v;
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                h = 0;
                v = 0;
            end else if (r == 1) begin
                h = 0;
                v = 480;
            end else if (r == 2) begin
                h = int'($urandom_range(0, 4095));
                v = int'($urandom_range(0, 4095));
            end else begin
                h = int'($urandom_range(0, 799));
                v = int'($urandom_range(0, 524));
            end
            if ($urandom_range(0, 7) == 0) ren = ~ren;
            step(h, v, 1'($urandom), 1'($urandom), 1'($urandom), ren);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
